instruction_fetch_controller: RTL and testbench
===============================================

Name: instruction_fetch_controller

Overview:
- Sequences the word-addressed instruction memory (instructionMemory) for the multi-cycle processor.
- Owns the fetch PC and drives the memory address bus.
- Waits the memory read latency, latches the returned word into the instruction register, and hands it to the control unit with a one-cycle valid pulse.
- Accepts PC redirects (branch/jump) at any time and aborts any fetch in flight.

Parameters:
- MEM_LATENCY, 1, clock edges from stable address to valid mem_instruction; legal range 1..15.
- IMEM_DEPTH, 256, number of instruction words; word addresses at or above this value are out of range.
- RESET_PC, 0, fetch PC value after reset.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  control unit requests the next instruction; level, sampled in IDLE and DONE.
- pc_load  in  1  redirect strobe; overrides all other activity.
- pc_next  in  32  redirect target word address.
- mem_address  out  32  to the instruction memory address bus; equals fetch_pc.
- mem_instruction  in  32  instruction memory read data.
- instruction  out  32  instruction register.
- pc  out  32  word address of the word currently held in instruction.
- pc_plus_one  out  32  pc + 1, combinational.
- instr_valid  out  1  one-cycle pulse when instruction and pc update.
- busy  out  1  high in WAIT.
- fetch_fault  out  1  sticky out-of-range flag.
- fetch_count  out  32  completed fetches; wraps at 2^32.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc = RESET_PC; state = IDLE; wait_cnt = 0.
  - instruction = 0, pc = 0, instr_valid = 0, busy = 0, fetch_fault = 0, fetch_count = 0.
  - Reset mid-fetch discards the fetch; no instr_valid is produced.
- mem_address is driven directly from the fetch_pc register, so it is stable for the whole cycle.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - fetch_req=1 and fetch_pc < IMEM_DEPTH: go to WAIT, wait_cnt <= MEM_LATENCY.
  - fetch_req=1 and fetch_pc >= IMEM_DEPTH: fetch_fault <= 1, stay in IDLE.
  - While fetch_fault=1, fetch_req is ignored.
- WAIT:
  - busy=1; wait_cnt decrements each edge.
  - On the edge where wait_cnt==1: instruction <= mem_instruction, pc <= fetch_pc, fetch_pc <= fetch_pc+1, fetch_count <= fetch_count+1, go to DONE.
- DONE:
  - instr_valid=1 for exactly this cycle.
  - Next edge: fetch_req=1 starts the next fetch immediately (same rules as IDLE, including the range check); otherwise go to IDLE.
- Latency: fetch_req sampled at edge E gives instr_valid high in the cycle after edge E+MEM_LATENCY. Back-to-back throughput is one instruction per MEM_LATENCY+1 cycles.
- pc_load=1 at an edge, in any state:
  - fetch_pc <= pc_next, state <= IDLE, wait_cnt <= 0, fetch_fault <= 0.
  - An in-flight capture in the same edge is discarded: instruction, pc and fetch_count are unchanged and no instr_valid follows.
  - pc_load has priority over fetch_req and over capture.
- Wrap-around: fetch_pc 32'hFFFF_FFFF increments to 0; fetch_count wraps to 0.
- instruction and pc hold their values indefinitely between fetches.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (IDLE, WAIT, DONE), 2 bits;
  - WORD_W = 32;
  - CNT_W = 4 (wait_cnt width, sized to MEM_LATENCY max 15).
- One natural sub-module, fetch_latency_counter: load, decrement, and an expire flag when the count equals 1. The rest stays in the top level.

Test Plan:
- Reset, then memory words 0..3 preloaded; fetch_req held high with MEM_LATENCY=1 -> instr_valid pulses every 2 cycles; pc = 0,1,2,3; instruction matches words 0..3; fetch_count = 4.
- MEM_LATENCY=3; single fetch_req pulse at edge E -> busy high 3 cycles, instr_valid only in the cycle after E+3, mem_address held at 0 throughout WAIT.
- pc_load=1, pc_next=0x10 during WAIT -> no instr_valid for the aborted fetch; instruction and pc unchanged; the next fetch returns word 0x10 with pc=0x10.
- pc_load and the capture edge coincide -> capture discarded, fetch_count unchanged, fetch_pc = pc_next.
- pc_load with pc_next=255, IMEM_DEPTH=256, fetch_req held high -> word 255 fetched; next request sets fetch_fault=1 with no busy; pc_load with pc_next=0 clears fetch_fault.
- reset asserted asynchronously mid-WAIT -> all outputs immediately at reset values; mem_address = RESET_PC; no instr_valid after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch controller.
//   WORD_W        : instruction / address word width
//   CNT_W         : width of the memory latency counter (MEM_LATENCY up to 15)
//   fetch_state_t : fetch sequencer states
package fetch_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_latency_counter.sv
// Down-counter that times the instruction memory read latency.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   load         : load load_value (start of a fetch)
//   clear        : force the count to zero (redirect abort)
//   dec          : decrement by one while non-zero
//   load_value   : latency to load
//   count        : current remaining count
//   expire       : high while count == 1, i.e. the next edge captures data
module fetch_latency_counter
  import fetch_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer for the multi-cycle processor. Owns the fetch
// PC, drives the word-addressed instruction memory, waits out its read
// latency, latches the returned word and presents it with a one-cycle valid.
// Ports:
//   clock, reset    : clock and asynchronous active-high reset
//   fetch_req       : level request for the next instruction (IDLE / DONE)
//   pc_load         : redirect strobe, highest priority
//   pc_next         : redirect target word address
//   mem_address     : instruction memory address (the fetch PC register)
//   mem_instruction : instruction memory read data
//   instruction     : instruction register
//   pc              : word address of the word held in instruction
//   pc_plus_one     : pc + 1
//   instr_valid     : one-cycle pulse after instruction/pc update
//   busy            : high while waiting on memory
//   fetch_fault     : sticky out-of-range fetch flag, cleared by pc_load
//   fetch_count     : number of completed fetches (wraps)
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter int                MEM_LATENCY = 1,
  parameter int                IMEM_DEPTH  = 256,
  parameter logic [WORD_W-1:0] RESET_PC    = '0
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [WORD_W-1:0] pc_next,
  output logic [WORD_W-1:0] mem_address,
  input  logic [WORD_W-1:0] mem_instruction,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus_one,
  output logic              instr_valid,
  output logic              busy,
  output logic              fetch_fault,
  output logic [WORD_W-1:0] fetch_count
);

  localparam logic [WORD_W-1:0] DEPTH_LIMIT = WORD_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0]  LATENCY     = CNT_W'(MEM_LATENCY);

  fetch_state_t      state, state_next;
  logic [WORD_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cnt_load, cnt_clear, cnt_dec, cnt_expire;
  logic              capture, set_fault, in_range, start_ok;

  fetch_latency_counter u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .clear      (cnt_clear),
    .dec        (cnt_dec),
    .load_value (LATENCY),
    .count      (wait_cnt),
    .expire     (cnt_expire)
  );

  assign in_range = (fetch_pc < DEPTH_LIMIT);
  // A latched fault blocks further requests until a redirect clears it.
  assign start_ok = fetch_req && !fetch_fault;
  assign cnt_dec  = (state == WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_clear  = 1'b0;
    capture    = 1'b0;
    set_fault  = 1'b0;
    if (pc_load) begin
      // Redirect wins over both new requests and a same-edge capture.
      state_next = IDLE;
      cnt_clear  = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          state_next = IDLE;
          if (start_ok) begin
            if (in_range) begin
              state_next = WAIT;
              cnt_load   = 1'b1;
            end else begin
              set_fault = 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt_expire) begin
            capture    = 1'b1;
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      instruction <= '0;
      pc          <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else if (pc_load) begin
      fetch_pc    <= pc_next;
      fetch_fault <= 1'b0;
    end else begin
      if (capture) begin
        instruction <= mem_instruction;
        pc          <= fetch_pc;
        fetch_pc    <= fetch_pc + WORD_W'(1);
        fetch_count <= fetch_count + WORD_W'(1);
      end
      if (set_fault) begin
        fetch_fault <= 1'b1;
      end
    end
  end

  assign mem_address = fetch_pc;
  assign pc_plus_one = pc + WORD_W'(1);
  assign instr_valid = (state == DONE);
  assign busy        = (state == WAIT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: two instances (latency 1 and 3)
// share all control inputs; each has its own latency-aware memory and a
// transaction-level reference model (in-flight flag plus capture deadline).
module tb_instruction_fetch_controller;

  logic        clock;
  logic        reset;
  logic        fetch_req;
  logic        pc_load;
  logic [31:0] pc_next;

  logic [31:0] mem_address     [2];
  logic [31:0] mem_instruction [2];
  logic [31:0] instruction     [2];
  logic [31:0] pc              [2];
  logic [31:0] pc_plus_one     [2];
  logic        instr_valid     [2];
  logic        busy            [2];
  logic        fetch_fault     [2];
  logic [31:0] fetch_count     [2];

  int total = 0;
  int bad   = 0;

  instruction_fetch_controller #(
    .MEM_LATENCY (1),
    .IMEM_DEPTH  (256),
    .RESET_PC    (32'd0)
  ) u0 (
    .clock           (clock),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .mem_address     (mem_address[0]),
    .mem_instruction (mem_instruction[0]),
    .instruction     (instruction[0]),
    .pc              (pc[0]),
    .pc_plus_one     (pc_plus_one[0]),
    .instr_valid     (instr_valid[0]),
    .busy            (busy[0]),
    .fetch_fault     (fetch_fault[0]),
    .fetch_count     (fetch_count[0])
  );

  instruction_fetch_controller #(
    .MEM_LATENCY (3),
    .IMEM_DEPTH  (256),
    .RESET_PC    (32'd0)
  ) u1 (
    .clock           (clock),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .pc_load         (pc_load),
    .pc_next         (pc_next),
    .mem_address     (mem_address[1]),
    .mem_instruction (mem_instruction[1]),
    .instruction     (instruction[1]),
    .pc              (pc[1]),
    .pc_plus_one     (pc_plus_one[1]),
    .instr_valid     (instr_valid[1]),
    .busy            (busy[1]),
    .fetch_fault     (fetch_fault[1]),
    .fetch_count     (fetch_count[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: data is only correct once the address has been held for the
  // instance's latency; before that it returns a recognisable junk value.
  int          lat_of [2] = '{1, 3};
  logic [31:0] mem [256];
  logic [31:0] last_addr [2];
  int          age [2] = '{0, 0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_address[i] === last_addr[i]) age[i] <= (age[i] < 100) ? age[i] + 1 : age[i];
      else age[i] <= 1;
      last_addr[i] <= mem_address[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mem_instruction[i] = 32'hDEAD_0000 ^ mem_address[i];
      if (mem_address[i] < 32'd256 &&
          ((mem_address[i] === last_addr[i]) ? age[i] : 0) >= lat_of[i] - 1)
        mem_instruction[i] = mem[mem_address[i][7:0]];
    end
  end

  // Reference model
  logic [31:0] m_pc [2], m_instr [2], m_pcreg [2], m_count [2];
  logic        m_fault [2], m_inflight [2], m_valid [2];
  int          m_deadline [2];
  int          ncyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'd0; m_instr[i] = 32'd0; m_pcreg[i] = 32'd0; m_count[i] = 32'd0;
      m_fault[i] = 1'b0; m_inflight[i] = 1'b0; m_valid[i] = 1'b0; m_deadline[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (pc_load) begin
        m_pc[i] = pc_next; m_inflight[i] = 1'b0; m_fault[i] = 1'b0;
      end else if (m_inflight[i] && ncyc == m_deadline[i]) begin
        m_instr[i] = mem[m_pc[i][7:0]];
        m_pcreg[i] = m_pc[i];
        m_pc[i] = m_pc[i] + 32'd1;
        m_count[i] = m_count[i] + 32'd1;
        m_inflight[i] = 1'b0;
        m_valid[i] = 1'b1;
      end else if (!m_inflight[i] && fetch_req && !m_fault[i]) begin
        if (m_pc[i] < 32'd256) begin
          m_inflight[i] = 1'b1;
          m_deadline[i] = ncyc + lat_of[i];
        end else begin
          m_fault[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.instr_valid", i), {31'd0, instr_valid[i]}, {31'd0, m_valid[i]});
      chk($sformatf("u%0d.busy", i), {31'd0, busy[i]}, {31'd0, m_inflight[i]});
      chk($sformatf("u%0d.fetch_fault", i), {31'd0, fetch_fault[i]}, {31'd0, m_fault[i]});
      chk($sformatf("u%0d.mem_address", i), mem_address[i], m_pc[i]);
      chk($sformatf("u%0d.instruction", i), instruction[i], m_instr[i]);
      chk($sformatf("u%0d.pc", i), pc[i], m_pcreg[i]);
      chk($sformatf("u%0d.pc_plus_one", i), pc_plus_one[i], m_pcreg[i] + 32'd1);
      chk($sformatf("u%0d.fetch_count", i), fetch_count[i], m_count[i]);
    end
  endtask

  task automatic step(input logic req, input logic ld, input logic [31:0] nxt);
    fetch_req = req;
    pc_load   = ld;
    pc_next   = nxt;
    @(posedge clock);
    ncyc++;
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_next = 32'd0;
    #1;
    model_reset();
    check_all();
    #8 reset = 1'b0;

    // Held request: latency-1 instance delivers words 0..3 in 8 cycles.
    repeat (8) step(1'b1, 1'b0, 32'd0);
    chk("tp1.count_u0", fetch_count[0], 32'd4);
    chk("tp1.pc_u0", pc[0], 32'd3);
    chk("tp1.instr_u0", instruction[0], mem[3]);
    repeat (6) step(1'b0, 1'b0, 32'd0);

    // Redirect: coincides with capture on u0, lands mid-wait on u1.
    step(1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h10);
    chk("tp3.mem_address_u0", mem_address[0], 32'h10);
    repeat (6) step(1'b1, 1'b0, 32'd0);
    repeat (4) step(1'b0, 1'b0, 32'd0);

    // Last in-range word, then out-of-range request faults; redirect clears.
    step(1'b0, 1'b1, 32'd255);
    repeat (12) step(1'b1, 1'b0, 32'd0);
    chk("tp5.fault_u1", {31'd0, fetch_fault[1]}, 32'd1);
    chk("tp5.pc_u1", pc[1], 32'd255);
    step(1'b0, 1'b1, 32'd0);
    chk("tp5.fault_clear_u0", {31'd0, fetch_fault[0]}, 32'd0);

    // Asynchronous reset while u1 is waiting on memory.
    step(1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #3 reset = 1'b0;
    repeat (5) step(1'b0, 1'b0, 32'd0);

    // Randomized traffic against the model.
    repeat (400) begin
      logic        r_req, r_ld;
      logic [31:0] r_nxt;
      int          sel;
      r_req = ($urandom_range(0, 3) != 0);
      r_ld  = ($urandom_range(0, 15) == 0);
      sel   = $urandom_range(0, 9);
      if (sel < 7)       r_nxt = 32'($urandom_range(0, 270));
      else if (sel == 7) r_nxt = 32'd255;
      else if (sel == 8) r_nxt = 32'hFFFF_FFFF;
      else               r_nxt = 32'd254;
      step(r_req, r_ld, r_nxt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
